// File: rtl/sine_phase_sequencer_pkg.sv
// Shared types and constants for the sine phase sequencer slice.
package sine_pkg;

  localparam int ADDR_W         = 7;
  localparam int STEPS_PER_QUAD = 128;
  localparam int NUM_QUAD       = 4;
  localparam int QUAD_W         = $clog2(NUM_QUAD);

  // Highest quarter-wave table address; the walk turns around here.
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(STEPS_PER_QUAD - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } seqState_e;

  // Quadrants 0 and 2 walk the table upwards, 1 and 3 walk it back down.
  function automatic logic quadAscending(input logic [QUAD_W-1:0] quad);
    return ~quad[0];
  endfunction

endpackage

// File: rtl/sine_phase_sequencer_if.sv
// Control and phase-output bundle between the sequencer and its user.
interface sine_phase_sequencer_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
);
  import sine_pkg::*;

  logic                start;
  logic                stop;
  logic [DIV_W-1:0]    div;
  logic [CNT_W-1:0]    ncycles;
  logic [ADDR_W-1:0]   addr;
  logic                sign;
  logic [QUAD_W-1:0]   quadrant;
  logic                busy;
  logic                step;
  logic                period_tick;
  logic                done;

  // The controller side drives requests and configuration.
  modport master (
    output start, stop, div, ncycles,
    input  addr, sign, quadrant, busy, step, period_tick, done
  );

  // The sequencer side consumes requests and produces the phase outputs.
  modport slave (
    input  start, stop, div, ncycles,
    output addr, sign, quadrant, busy, step, period_tick, done
  );

endinterface

// File: rtl/sine_phase_sequencer_step_timer.sv
// Step-rate timer: down-counter that fires a step enable every reload+1 clocks.
module sine_step_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic [DIV_W-1:0] reload_i,
  output logic             stepEn_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // While idle the counter sits preloaded so the first address is held a full interval.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || (cnt_q == '0)) begin
      cnt_d = reload_i;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stepEn_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/sine_phase_sequencer.sv
// Sine phase sequencer: walks the quarter-wave address through four quadrants
// per period, with burst/continuous operation and zero-crossing-only stopping.
module sine_phase_sequencer
  import sine_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sine_phase_sequencer_if.slave bus
);

  seqState_e           state_q;
  logic [DIV_W-1:0]    div_q;
  logic [CNT_W-1:0]    burst_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_d;
  logic [QUAD_W-1:0]   quad_q;
  logic [QUAD_W-1:0]   quad_d;
  logic                sign_q;
  logic                busy_q;
  logic                step_q;
  logic                tick_q;
  logic                done_q;

  logic                running;
  logic                stepEn;
  logic                lastStep;
  logic                periodEnd;
  logic                runEnds;
  logic [DIV_W-1:0]    timerReload;

  sine_step_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (running),
    .reload_i (timerReload),
    .stepEn_o (stepEn)
  );

  // Step bookkeeping: next address/quadrant, period boundary and end-of-run decision.
  always_comb begin
    running   = (state_q != IDLE);
    lastStep  = (quad_q == QUAD_W'(NUM_QUAD - 1)) && (addr_q == '0);
    periodEnd = stepEn && lastStep;
    runEnds   = periodEnd &&
                ((state_q == STOPPING) || bus.stop || (burst_q == CNT_W'(1)));
    // A new div only takes effect at start or at the zero crossing.
    timerReload = (!running || periodEnd) ? bus.div : div_q;

    addr_d = addr_q;
    quad_d = quad_q;
    if (quadAscending(quad_q)) begin
      if (addr_q == ADDR_MAX) begin
        quad_d = quad_q + QUAD_W'(1);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end else begin
      if (addr_q == '0) begin
        quad_d = quad_q + QUAD_W'(1);
      end else begin
        addr_d = addr_q - ADDR_W'(1);
      end
    end
  end

  // Control FSM with registered phase outputs and burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      quad_q  <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // A stop arriving with start is simply carried into the first period.
            state_q <= bus.stop ? STOPPING : RUN;
            div_q   <= bus.div;
            burst_q <= bus.ncycles;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            quad_q  <= '0;
            sign_q  <= 1'b0;
          end
        end
        RUN, STOPPING: begin
          if (runEnds) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            quad_q  <= '0;
            sign_q  <= 1'b0;
            tick_q  <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            if ((state_q == RUN) && bus.stop) begin
              state_q <= STOPPING;
            end
            if (stepEn) begin
              addr_q <= addr_d;
              quad_q <= quad_d;
              sign_q <= quad_d[QUAD_W-1];
              step_q <= 1'b1;
            end
            if (periodEnd) begin
              tick_q <= 1'b1;
              div_q  <= bus.div;
              if (burst_q != '0) begin
                burst_q <= burst_q - CNT_W'(1);
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.addr        = addr_q;
  assign bus.sign        = sign_q;
  assign bus.quadrant    = quad_q;
  assign bus.busy        = busy_q;
  assign bus.step        = step_q;
  assign bus.period_tick = tick_q;
  assign bus.done        = done_q;

endmodule
